digit_serial_adder: RTL



---
 rtl/digit_serial_adder_pkg.sv | 18 +
 rtl/digit_add.sv | 28 ++
 rtl/digit_serial_adder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package digit_serial_adder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Counter width for NDIG digits; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned ndig);
      if (ndig <= 1) begin
         return 1;
      end
      return int'($clog2(ndig));
   endfunction

endpackage

// File: rtl/digit_add.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into the top bit.
module digit_add #(
   parameter int unsigned DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             cin,
   output logic [DIGIT-1:0] s_d,
   output logic             cout,
   output logic             c_msb_in
);

   always_comb begin
      logic c;
      c        = cin;
      c_msb_in = cin;
      s_d      = '0;
      for (int i = 0; i < int'(DIGIT); i++) begin
         if (i == int'(DIGIT) - 1) begin
            c_msb_in = c;
         end
         s_d[i] = a_d[i] ^ b_d[i] ^ c;
         c      = (a_d[i] & b_d[i]) | (c & (a_d[i] ^ b_d[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract, DIGIT bits per clock, valid/ready on both sides.
// Optional accumulate input enabled by defining DIGIT_SERIAL_ADDER_ACC_EN.
module digit_serial_adder
   import digit_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
`ifdef DIGIT_SERIAL_ADDER_ACC_EN
   input  logic             acc,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CntW = cnt_width(NDIG);

   if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q;
   logic [CntW-1:0]  cnt_q;
   logic             carry_out_q, overflow_q;

   logic [DIGIT-1:0]       digit_sum;
   logic                   digit_cout, digit_c_msb;
   logic                   last_digit, accept;
   logic [WIDTH-1:0]       a_src;
   logic [WIDTH+DIGIT-1:0] sum_shift;

   digit_add #(
      .DIGIT(DIGIT)
   ) u_digit_add (
      .a_d     (a_q[DIGIT-1:0]),
      .b_d     (b_q[DIGIT-1:0]),
      .cin     (carry_q),
      .s_d     (digit_sum),
      .cout    (digit_cout),
      .c_msb_in(digit_c_msb)
   );

   assign last_digit = (cnt_q == CntW'(NDIG - 1));
   assign accept     = in_valid && in_ready;
   // New digit enters at the MSB end; after NDIG shifts the LSB digit lands at bit 0.
   assign sum_shift  = {digit_sum, sum_q};

`ifdef DIGIT_SERIAL_ADDER_ACC_EN
   assign a_src = acc ? sum_q : a;
`else
   assign a_src = a;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = StRun;
         StRun:   if (last_digit) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == StIdle) && !rst;
      out_valid = (state_q == StDone);
      sum       = sum_q;
      carry_out = carry_out_q;
      overflow  = overflow_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  a_q     <= a_src;
                  b_q     <= b ^ {WIDTH{sub}};
                  carry_q <= sub;
                  cnt_q   <= '0;
               end
            end
            StRun: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               sum_q   <= sum_shift[WIDTH+DIGIT-1:DIGIT];
               carry_q <= digit_cout;
               cnt_q   <= cnt_q + CntW'(1);
               if (last_digit) begin
                  carry_out_q <= digit_cout;
                  overflow_q  <= digit_c_msb ^ digit_cout;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
